// File: rtl/ece429_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ece429_mem_arbiter
//
// Shares one single-ported ECE429_Memory between the SREC loader, the data
// (M) stage and the instruction fetch stage. One access is in flight at a
// time; the winning command is registered onto the memory port and held for
// MEM_LATENCY cycles, then the read data is captured and a one-cycle valid
// pulse is returned to the winner. cpu_stall holds the pipeline while the
// loader owns (or is asking for) the memory.
//
// Parameters
//   MEM_LATENCY   cycles the memory port is held per access (>= 1)
//   STARVE_LIMIT  consecutive data grants, with i_req pending, after which
//                 fetch is forced to win the next arbitration
//
// Ports
//   clock, reset                   rising-edge clock, async active-high reset
//   load_req/addr/data/size        loader write request and operands
//   load_grant                     loader accepted (combinational pulse)
//   d_req/we/addr/size/wdata       data-stage request and operands
//   d_grant                        data accepted (combinational pulse)
//   d_valid, d_rdata               data access done (registered pulse) + data
//   i_req/addr/size                fetch request (always a read)
//   i_grant                        fetch accepted (combinational pulse)
//   i_valid, i_rdata               fetch done (registered pulse) + word
//   mem_addr/datain/access_size    registered command to the memory
//   mem_r_w                        registered direction, 1 = write
//   mem_dataout                    read data from the memory
//   cpu_stall                      hold the pipeline
//
// FSM states
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | memory free; arbitrate and issue at most one grant
//   S_BUSY | access in flight; mem_* held, cnt counts down to completion
// ---------------------------------------------------------------------------
module ece429_mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_size,
  output logic        load_grant,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_grant,
  output logic        d_valid,
  output logic [31:0] d_rdata,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  output logic        i_grant,
  output logic        i_valid,
  output logic [31:0] i_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [1:0]  mem_access_size,
  output logic        mem_r_w,
  input  logic [31:0] mem_dataout,

  output logic        cpu_stall
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int unsigned STK_W = $clog2(STARVE_LIMIT + 2);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_LOAD  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2
  } owner_t;

  state_t           state_q,      state_d;
  owner_t           owner_q,      owner_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [STK_W-1:0] streak_q,     streak_d;
  logic [31:0]      mem_addr_q,   mem_addr_d;
  logic [31:0]      mem_datain_q, mem_datain_d;
  logic [1:0]       mem_size_q,   mem_size_d;
  logic             mem_r_w_q,    mem_r_w_d;
  logic             d_valid_q,    d_valid_d;
  logic             i_valid_q,    i_valid_d;
  logic [31:0]      d_rdata_q,    d_rdata_d;
  logic [31:0]      i_rdata_q,    i_rdata_d;

  logic idle;
  logic force_fetch;

  // Grants are only offered from a settled IDLE state; while reset is held
  // the arbiter must not accept anything.
  assign idle        = (state_q == S_IDLE) && !reset;
  assign force_fetch = i_req && (streak_q == STK_MAX);

  // Loader always wins; fetch overtakes data once data has starved it.
  assign load_grant = idle && load_req;
  assign d_grant    = idle && !load_req && d_req && !force_fetch;
  assign i_grant    = idle && !load_req && i_req && (!d_req || force_fetch);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    mem_size_d   = mem_size_q;
    mem_r_w_d    = mem_r_w_q;
    d_valid_d    = 1'b0;
    i_valid_d    = 1'b0;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Streak only tracks data grants that actually kept fetch waiting.
        if (i_grant || !i_req) begin
          streak_d = '0;
        end else if (d_grant && (streak_q != STK_MAX)) begin
          streak_d = streak_q + STK_ONE;
        end

        if (load_grant) begin
          state_d      = S_BUSY;
          owner_d      = OWN_LOAD;
          cnt_d        = CNT_LOAD;
          mem_addr_d   = load_addr;
          mem_datain_d = load_data;
          mem_size_d   = load_size;
          mem_r_w_d    = 1'b1;
        end else if (d_grant) begin
          state_d      = S_BUSY;
          owner_d      = OWN_DATA;
          cnt_d        = CNT_LOAD;
          mem_addr_d   = d_addr;
          mem_datain_d = d_wdata;
          mem_size_d   = d_size;
          mem_r_w_d    = d_we;
        end else if (i_grant) begin
          state_d      = S_BUSY;
          owner_d      = OWN_FETCH;
          cnt_d        = CNT_LOAD;
          mem_addr_d   = i_addr;
          mem_datain_d = '0;
          mem_size_d   = i_size;
          mem_r_w_d    = 1'b0;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        // Terminal count: the memory has had its full latency, so its output
        // is valid now and the port can be released in the same edge.
        if (cnt_q == CNT_ONE) begin
          state_d   = S_IDLE;
          mem_r_w_d = 1'b0;
          case (owner_q)
            OWN_DATA: begin
              d_valid_d = 1'b1;
              d_rdata_d = mem_dataout;
            end
            OWN_FETCH: begin
              i_valid_d = 1'b1;
              i_rdata_d = mem_dataout;
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_LOAD;
      cnt_q        <= '0;
      streak_q     <= '0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      mem_size_q   <= '0;
      mem_r_w_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      i_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_size_q   <= mem_size_d;
      mem_r_w_q    <= mem_r_w_d;
      d_valid_q    <= d_valid_d;
      i_valid_q    <= i_valid_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
    end
  end

  assign mem_addr        = mem_addr_q;
  assign mem_datain      = mem_datain_q;
  assign mem_access_size = mem_size_q;
  assign mem_r_w         = mem_r_w_q;
  assign d_valid         = d_valid_q;
  assign d_rdata         = d_rdata_q;
  assign i_valid         = i_valid_q;
  assign i_rdata         = i_rdata_q;

  // Stall as soon as the loader asks, and for the whole of its access.
  assign cpu_stall = reset || load_req || ((state_q == S_BUSY) && (owner_q == OWN_LOAD));

endmodule

// File: tb/tb_ece429_mem_arbiter.sv
module tb_ece429_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [1:0]  load_size;
  logic        load_grant;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_grant;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        i_grant;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [1:0]  mem_access_size;
  logic        mem_r_w;
  logic [31:0] mem_dataout;
  logic        cpu_stall;

  int n_checks = 0;
  int n_fail   = 0;

  ece429_mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_size(load_size), .load_grant(load_grant),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_grant(i_grant),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_access_size(mem_access_size), .mem_r_w(mem_r_w),
    .mem_dataout(mem_dataout), .cpu_stall(cpu_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: combinational read, write on the clock edge while r_w=1.
  // Unwritten words return a fixed, address-derived pattern.
  logic [31:0]  mem_arr [0:255];
  logic [255:0] mem_wr = '0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h2402_0005;
    return {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clock) begin
    if (mem_r_w) begin
      mem_arr[mem_addr[9:2]] <= mem_datain;
      mem_wr[mem_addr[9:2]]  <= 1'b1;
    end
  end

  assign mem_dataout = mem_wr[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : mem_init(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the
  // falling edge in the middle of the same cycle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic clear_reqs();
    load_req = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    i_req    = 1'b0;
  endtask

  // {d_grant, i_grant, d_valid, i_valid} per cycle for the starvation run
  logic [3:0] starve_exp [0:15];

  initial begin
    starve_exp = '{4'b1000, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000,
                   4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000,
                   4'b0110, 4'b0000, 4'b0000, 4'b1001};

    reset     = 1'b1;
    clear_reqs();
    load_addr = '0; load_data = '0; load_size = 2'd2;
    d_addr    = '0; d_size    = 2'd2; d_wdata = '0;
    i_addr    = '0; i_size    = 2'd2;

    // Reset state
    cyc(); mid();
    check("rst_stall",   {31'd0, cpu_stall}, 32'd1);
    check("rst_rw",      {31'd0, mem_r_w},   32'd0);
    check("rst_addr",    mem_addr,           32'd0);
    check("rst_datain",  mem_datain,         32'd0);
    check("rst_valids",  {30'd0, d_valid, i_valid}, 32'd0);
    check("rst_rdata",   d_rdata | i_rdata,  32'd0);
    i_req = 1'b1;
    mid(); mid();
    check("rst_nogrant", {29'd0, load_grant, d_grant, i_grant}, 32'd0);
    i_req = 1'b0;
    cyc(); reset = 1'b0; mid();
    check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    cyc(); cyc();

    // 1: single fetch
    i_req = 1'b1; i_addr = 32'h10; mid();
    check("t1_igrant", {31'd0, i_grant}, 32'd1);
    cyc(); i_req = 1'b0; mid();
    check("t1_addr", mem_addr, 32'h10);
    check("t1_rw",   {31'd0, mem_r_w}, 32'd0);
    cyc(); mid();
    check("t1_ivalid_c2", {31'd0, i_valid}, 32'd0);
    cyc(); mid();
    check("t1_ivalid_c3", {31'd0, i_valid}, 32'd1);
    check("t1_irdata",    i_rdata, 32'h2402_0005);
    cyc(); mid();
    check("t1_ivalid_c4", {31'd0, i_valid}, 32'd0);
    cyc(); cyc();

    // 2: data beats fetch, fetch follows in the valid cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h14; mid();
    check("t2_grants_c0", {30'd0, d_grant, i_grant}, 32'b10);
    cyc(); d_req = 1'b0; mid();
    check("t2_grants_c1", {30'd0, d_grant, i_grant}, 32'b00);
    cyc(); mid();
    cyc(); mid();
    check("t2_c3", {29'd0, i_grant, d_valid, i_valid}, 32'b110);
    check("t2_drdata", d_rdata, 32'h0100_C0DE);
    cyc(); i_req = 1'b0; mid();
    cyc(); mid();
    cyc(); mid();
    check("t2_ivalid_c6", {31'd0, i_valid}, 32'd1);
    check("t2_irdata",    i_rdata, 32'h0014_C0DE);
    cyc(); cyc();

    // 3: starvation limit forces fetch after four data grants
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h18;
    for (int k = 0; k < 16; k++) begin
      mid();
      check($sformatf("t3_c%0d", k), {28'd0, d_grant, i_grant, d_valid, i_valid},
            {28'd0, starve_exp[k]});
      cyc();
    end
    clear_reqs();
    cyc(); cyc(); cyc();

    // 4: loader write stalls the CPU and blocks fetch
    load_req = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h1C; mid();
    check("t4_c0", {29'd0, load_grant, i_grant, cpu_stall}, 32'b101);
    cyc(); load_req = 1'b0; mid();
    check("t4_c1", {29'd0, mem_r_w, i_grant, cpu_stall}, 32'b101);
    check("t4_addr",   mem_addr,   32'h20);
    check("t4_datain", mem_datain, 32'hDEAD_BEEF);
    cyc(); mid();
    check("t4_c2", {29'd0, mem_r_w, i_grant, cpu_stall}, 32'b101);
    cyc(); mid();
    check("t4_c3", {29'd0, mem_r_w, i_grant, cpu_stall}, 32'b010);
    check("t4_novalid", {30'd0, d_valid, i_valid}, 32'd0);
    cyc(); i_req = 1'b0;
    cyc(); cyc(); cyc();

    // 5: read back the loaded word
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; mid();
    check("t5_dgrant", {31'd0, d_grant}, 32'd1);
    cyc(); d_req = 1'b0;
    cyc(); cyc(); mid();
    check("t5_dvalid", {31'd0, d_valid}, 32'd1);
    check("t5_drdata", d_rdata, 32'hDEAD_BEEF);
    cyc(); cyc();

    // 6: reset in the middle of a data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678; mid();
    check("t6_dgrant", {31'd0, d_grant}, 32'd1);
    cyc(); d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h10; mid();
    check("t6_c1", {30'd0, mem_r_w, i_grant}, 32'b10);
    cyc(); reset = 1'b1; mid();
    check("t6_c2", {28'd0, mem_r_w, cpu_stall, i_grant, d_valid}, 32'b0100);
    check("t6_addr", mem_addr, 32'd0);
    cyc(); reset = 1'b0; mid();
    check("t6_c3", {30'd0, i_grant, d_valid}, 32'b10);
    cyc(); i_req = 1'b0; mid();
    check("t6_c4_dvalid", {31'd0, d_valid}, 32'd0);
    cyc(); mid();
    cyc(); mid();
    check("t6_c6", {30'd0, d_valid, i_valid}, 32'b01);
    check("t6_irdata", i_rdata, 32'h2402_0005);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
